// File: rtl/pc_stream_checker_pkg.sv
// Shared types for the fetch-stream checker.
// FSM states, error codes and instruction size.
package types_pkg;

  localparam int PCC_INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    PCC_IDLE,
    PCC_RUN,
    PCC_REDIR
  } pcc_state_e;

  typedef enum logic [2:0] {
    PCC_ERR_NONE  = 3'd0,
    PCC_ERR_SEQ   = 3'd1,
    PCC_ERR_REDIR = 3'd2,
    PCC_ERR_CNT   = 3'd3,
    PCC_ERR_ALIGN = 3'd4
  } pcc_err_e;

endpackage

// File: rtl/pc_stream_checker_if.sv
// Observed fetch/redirect/mispredict stream plus checker results.
// master = stream source side, slave = checker side.
interface pc_stream_checker_if #(
  parameter int XLEN    = 32,
  parameter int FETCH_W = 1,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 16
);
  localparam int CW = $clog2(FETCH_W + 1);

  logic             clear;
  logic             fetch_fire;
  logic [XLEN-1:0]  fetch_pc;
  logic [CW-1:0]    fetch_cnt;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             mispredict;
  logic [TAG_W-1:0] mispredict_tag;

  logic             err_sticky;
  logic [2:0]       err_code;
  logic [XLEN-1:0]  err_pc_got;
  logic [XLEN-1:0]  err_pc_exp;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] redirect_count;
  logic [CNT_W-1:0] mispredict_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output clear, fetch_fire, fetch_pc, fetch_cnt,
    output redirect, redirect_pc,
    output mispredict, mispredict_tag,
    input  err_sticky, err_code,
    input  err_pc_got, err_pc_exp,
    input  fetch_count, redirect_count,
    input  mispredict_count, err_count
  );

  modport slave (
    input  clear, fetch_fire, fetch_pc, fetch_cnt,
    input  redirect, redirect_pc,
    input  mispredict, mispredict_tag,
    output err_sticky, err_code,
    output err_pc_got, err_pc_exp,
    output fetch_count, redirect_count,
    output mispredict_count, err_count
  );

endinterface

// File: rtl/pc_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pc_stream_checker.sv
// Fetch-stream PC checker: sequential/redirect PC checks,
// mispredict de-dup, first-error capture, event counters.
module pc_stream_checker
  import types_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int FETCH_W = 1,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset,
  pc_stream_checker_if.slave b_out
);

  localparam int CW = $clog2(FETCH_W + 1);

  logic             clear;
  logic             fetch_fire;
  logic [XLEN-1:0]  fetch_pc;
  logic [CW-1:0]    fetch_cnt;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             mispredict;
  logic [TAG_W-1:0] mispredict_tag;
  logic [XLEN-1:0]  pc_reg;

  assign clear          = b_out.clear;
  assign fetch_fire     = b_out.fetch_fire;
  assign fetch_pc       = b_out.fetch_pc;
  assign fetch_cnt      = b_out.fetch_cnt;
  assign redirect       = b_out.redirect;
  assign redirect_pc    = b_out.redirect_pc;
  assign mispredict     = b_out.mispredict;
  assign mispredict_tag = b_out.mispredict_tag;

  pcc_state_e       state_q, state_d;
  logic [XLEN-1:0]  exp_pc_q, exp_pc_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic [TAG_W-1:0] last_tag_q, last_tag_d;
  logic             seen_q, seen_d;
  logic             err_sticky_q, err_sticky_d;
  pcc_err_e         err_code_q, err_code_d;
  logic [XLEN-1:0]  err_pc_got_q, err_pc_got_d;
  logic [XLEN-1:0]  err_pc_exp_q, err_pc_exp_d;

  logic             cnt_bad;
  logic             align_bad;
  logic             redir_bad;
  logic             seq_bad;
  pcc_err_e         err_kind;
  logic [XLEN-1:0]  err_exp;
  logic [XLEN-1:0]  next_pc;
  logic             err_hit;
  logic             mp_hit;

  assign pc_reg = exp_pc_q;

  assign cnt_bad   = (fetch_cnt == '0)
                   || (fetch_cnt > CW'(FETCH_W));
  assign align_bad = (fetch_pc[1:0] != 2'b00);
  assign redir_bad = (state_q == PCC_REDIR)
                   && (fetch_pc != pend_pc_q);
  assign seq_bad   = (state_q == PCC_RUN)
                   && (fetch_pc != pc_reg);
  assign next_pc   = fetch_pc
                   + XLEN'(fetch_cnt) * XLEN'(PCC_INSTR_BYTES);

  // Only the highest-priority failing check is reported.
  always_comb begin
    err_kind = PCC_ERR_NONE;
    err_exp  = '0;
    if (cnt_bad) begin
      err_kind = PCC_ERR_CNT;
    end else if (align_bad) begin
      err_kind = PCC_ERR_ALIGN;
    end else if (redir_bad) begin
      err_kind = PCC_ERR_REDIR;
      err_exp  = pend_pc_q;
    end else if (seq_bad) begin
      err_kind = PCC_ERR_SEQ;
      err_exp  = pc_reg;
    end
  end

  assign err_hit = fetch_fire && (err_kind != PCC_ERR_NONE);
  assign mp_hit  = mispredict
                 && (!seen_q || (mispredict_tag != last_tag_q));

  always_comb begin
    state_d      = state_q;
    exp_pc_d     = exp_pc_q;
    pend_pc_d    = pend_pc_q;
    last_tag_d   = last_tag_q;
    seen_d       = seen_q;
    err_sticky_d = err_sticky_q;
    err_code_d   = err_code_q;
    err_pc_got_d = err_pc_got_q;
    err_pc_exp_d = err_pc_exp_q;

    if (fetch_fire) begin
      state_d = PCC_RUN;
      if (!cnt_bad) begin
        exp_pc_d = next_pc;
      end
      if (err_hit && !err_sticky_q) begin
        err_sticky_d = 1'b1;
        err_code_d   = err_kind;
        err_pc_got_d = fetch_pc;
        err_pc_exp_d = err_exp;
      end
    end

    // A same-cycle redirect targets the following fetch.
    if (redirect) begin
      pend_pc_d = redirect_pc;
      state_d   = PCC_REDIR;
    end

    if (mp_hit) begin
      last_tag_d = mispredict_tag;
      seen_d     = 1'b1;
    end

    if (clear) begin
      state_d      = PCC_IDLE;
      exp_pc_d     = '0;
      pend_pc_d    = '0;
      last_tag_d   = '0;
      seen_d       = 1'b0;
      err_sticky_d = 1'b0;
      err_code_d   = PCC_ERR_NONE;
      err_pc_got_d = '0;
      err_pc_exp_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PCC_IDLE;
      exp_pc_q     <= '0;
      pend_pc_q    <= '0;
      last_tag_q   <= '0;
      seen_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      err_code_q   <= PCC_ERR_NONE;
      err_pc_got_q <= '0;
      err_pc_exp_q <= '0;
    end else begin
      state_q      <= state_d;
      exp_pc_q     <= exp_pc_d;
      pend_pc_q    <= pend_pc_d;
      last_tag_q   <= last_tag_d;
      seen_q       <= seen_d;
      err_sticky_q <= err_sticky_d;
      err_code_q   <= err_code_d;
      err_pc_got_q <= err_pc_got_d;
      err_pc_exp_q <= err_pc_exp_d;
    end
  end

  logic [CNT_W-1:0] fetch_cnt_q;
  logic [CNT_W-1:0] redir_cnt_q;
  logic [CNT_W-1:0] mp_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (fetch_fire),
    .clr   (clear),
    .q     (fetch_cnt_q)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .clr   (clear),
    .q     (redir_cnt_q)
  );

  sat_counter #(.W(CNT_W)) u_mp_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mp_hit),
    .clr   (clear),
    .q     (mp_cnt_q)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_hit),
    .clr   (clear),
    .q     (err_cnt_q)
  );

  assign b_out.err_sticky       = err_sticky_q;
  assign b_out.err_code         = err_code_q;
  assign b_out.err_pc_got       = err_pc_got_q;
  assign b_out.err_pc_exp       = err_pc_exp_q;
  assign b_out.fetch_count      = fetch_cnt_q;
  assign b_out.redirect_count   = redir_cnt_q;
  assign b_out.mispredict_count = mp_cnt_q;
  assign b_out.err_count        = err_cnt_q;

endmodule

// File: tb/tb_pc_stream_checker.sv
// Directed bench for pc_stream_checker (FETCH_W=4, CNT_W=4).
// Hand-computed expectations, one compare task.
module tb_pc_stream_checker;

  localparam int XLEN    = 32;
  localparam int FETCH_W = 4;
  localparam int TAG_W   = 5;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pc_stream_checker_if #(
    .XLEN(XLEN), .FETCH_W(FETCH_W),
    .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) bus ();

  pc_stream_checker #(
    .XLEN(XLEN), .FETCH_W(FETCH_W),
    .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .b_out (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.clear          = 1'b0;
    bus.fetch_fire     = 1'b0;
    bus.fetch_pc       = '0;
    bus.fetch_cnt      = '0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    bus.mispredict     = 1'b0;
    bus.mispredict_tag = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic fetch(input logic [31:0] pc, input int cnt);
    bus.fetch_fire = 1'b1;
    bus.fetch_pc   = pc;
    bus.fetch_cnt  = 3'(cnt);
    cyc();
  endtask

  task automatic redir(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    cyc();
  endtask

  task automatic mp(input int tag);
    bus.mispredict     = 1'b1;
    bus.mispredict_tag = 5'(tag);
    cyc();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_in();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_sticky", 32'(bus.err_sticky), 0);
    chk("rst_code", 32'(bus.err_code), 0);
    chk("rst_fcnt", 32'(bus.fetch_count), 0);

    // Sequential stream with redirect riding on the 0x8 fetch.
    fetch(32'h0, 1);
    fetch(32'h4, 1);
    chk("seq_sticky", 32'(bus.err_sticky), 0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    fetch(32'h8, 1);
    chk("seq_fcnt3", 32'(bus.fetch_count), 3);
    fetch(32'h40, 1);
    chk("redir_ok_sticky", 32'(bus.err_sticky), 0);
    chk("redir_cnt1", 32'(bus.redirect_count), 1);

    do_clear();
    fetch(32'h0, 1);
    fetch(32'h4, 1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    fetch(32'h8, 1);
    fetch(32'hC, 1);
    chk("redir_code", 32'(bus.err_code), 2);
    chk("redir_got", bus.err_pc_got, 32'hC);
    chk("redir_exp", bus.err_pc_exp, 32'h40);
    chk("redir_errcnt", 32'(bus.err_count), 1);

    // Two redirects before a fetch: latest target wins.
    redir(32'h300);
    redir(32'h400);
    fetch(32'h400, 1);
    chk("redir2_cnt", 32'(bus.redirect_count), 3);
    chk("redir2_errcnt", 32'(bus.err_count), 1);

    do_clear();
    fetch(32'h100, 4);
    fetch(32'h108, 1);
    chk("grp_code", 32'(bus.err_code), 1);
    chk("grp_exp", bus.err_pc_exp, 32'h110);
    chk("grp_got", bus.err_pc_got, 32'h108);
    chk("grp_errcnt1", 32'(bus.err_count), 1);
    fetch(32'h200, 1);
    chk("grp_code_hold", 32'(bus.err_code), 1);
    chk("grp_errcnt2", 32'(bus.err_count), 2);
    chk("grp_got_hold", bus.err_pc_got, 32'h108);

    do_clear();
    fetch(32'h200, 0);
    chk("cnt_code", 32'(bus.err_code), 3);
    chk("cnt_exp", bus.err_pc_exp, 0);
    chk("cnt_got", bus.err_pc_got, 32'h200);
    fetch(32'h202, 1);
    chk("align_errcnt", 32'(bus.err_count), 2);
    chk("align_code_hold", 32'(bus.err_code), 3);

    // cnt=4 is legal, cnt=5 is not; exp_pc survives a CNT error.
    do_clear();
    fetch(32'h500, 4);
    chk("cnt4_ok", 32'(bus.err_sticky), 0);
    fetch(32'h510, 5);
    chk("cnt5_code", 32'(bus.err_code), 3);
    fetch(32'h510, 1);
    chk("cnt_hold_exp", 32'(bus.err_count), 1);

    do_clear();
    fetch(32'hFFFF_FFFC, 1);
    fetch(32'h0, 1);
    chk("wrap_ok", 32'(bus.err_sticky), 0);

    do_clear();
    repeat (5) mp(7);
    chk("mp_dedup", 32'(bus.mispredict_count), 1);
    mp(3);
    mp(7);
    chk("mp_cnt3", 32'(bus.mispredict_count), 3);
    do_clear();
    chk("clr_mp", 32'(bus.mispredict_count), 0);
    chk("clr_fcnt", 32'(bus.fetch_count), 0);
    chk("clr_sticky", 32'(bus.err_sticky), 0);
    fetch(32'h1234, 1);
    chk("clr_unchecked", 32'(bus.err_sticky), 0);
    mp(7);
    chk("clr_seen", 32'(bus.mispredict_count), 1);
    bus.clear = 1'b1;
    bus.mispredict     = 1'b1;
    bus.mispredict_tag = 5'd9;
    fetch(32'h3, 0);
    chk("clr_prio_f", 32'(bus.fetch_count), 0);
    chk("clr_prio_e", 32'(bus.err_sticky), 0);
    chk("clr_prio_m", 32'(bus.mispredict_count), 0);

    for (int i = 0; i < 20; i++) begin
      fetch(32'(i * 4), 1);
    end
    chk("sat_fcnt", 32'(bus.fetch_count), 15);
    chk("sat_sticky", 32'(bus.err_sticky), 0);

    redir(32'h80);
    rst_n = 1'b0;
    #2;
    chk("mrst_fcnt", 32'(bus.fetch_count), 0);
    chk("mrst_rcnt", 32'(bus.redirect_count), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fetch(32'h999C, 1);
    chk("mrst_nochk", 32'(bus.err_sticky), 0);
    fetch(32'h1000, 1);
    chk("mrst_seq_code", 32'(bus.err_code), 1);
    chk("mrst_seq_exp", bus.err_pc_exp, 32'h99A0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
